mc_regfile: RTL and testbench
=============================

Name: mc_regfile

Overview:
- 32x32-bit MIPS register file for the multicycle CPU.
- Sits directly downstream of the 5-bit write-register select mux (rt/rd); that mux output drives WriteReg here.
- Two read ports with registered outputs, acting as the datapath's A/B latches. One write port.
- Storage is cleared by a post-reset sweep FSM so the array maps to RAM without per-bit reset.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ReadReg1  in  ADDR_W  rs address (port A).
- ReadReg2  in  ADDR_W  rt address (port B).
- WriteReg  in  ADDR_W  write address, from the rt/rd select mux.
- WriteData  in  DATA_W  write data (ALUOut or MDR via MemtoReg mux).
- RegWrite  in  1  write strobe, one cycle per write.
- A  out  DATA_W  registered read of ReadReg1.
- B  out  DATA_W  registered read of ReadReg2.
- Ready  out  1  high when the clear sweep is done and the file accepts accesses.

Behaviour:
- Reset:
  - When rst=1 at a rising edge: A=0, B=0, Ready=0, FSM=CLEAR, sweep counter=0.
  - Reset mid-sweep or mid-operation restarts the sweep from 0.
- FSM states:
  - CLEAR: each cycle, write 0 to entry[counter], then counter+1. RegWrite is ignored. A and B hold 0.
  - At counter=2**ADDR_W-1, write that entry, then go to RUN next cycle.
  - RUN: Ready=1. FSM stays in RUN until rst.
  - Sweep length is exactly 32 cycles. Ready rises on the 33rd edge after rst deasserts.
- Write (RUN only):
  - If RegWrite=1 and WriteReg!=0, then entry[WriteReg] <= WriteData at the edge.
  - Writes to address 0 are discarded.
- Read (RUN only):
  - Every edge: A <= (ReadReg1==0 ? 0 : entry[ReadReg1]); B likewise from ReadReg2.
  - Latency is 1 cycle.
  - Read data is the array contents before any write at the same edge (read-before-write), unless the bypass feature below is compiled in.
- $0 always reads 0, independent of array contents.
- Same address on both read ports: A and B are identical.
- X/unknown addresses are not checked; behaviour is undefined.

Optional Feature:
- Macro: MC_REGFILE_BYPASS_EN.
- Defined: when RegWrite=1, WriteReg!=0, and WriteReg==ReadRegN in the same cycle, A/B capture WriteData (write-through). $0 still reads 0.
- Undefined: read-before-write as above; the old value is captured.
- The macro has no effect during CLEAR.

Decomposition:
- Shared package (mc_pkg):
  - REG_ZERO = 5'd0.
  - NUM_REGS = 32.
  - Typedefs reg_addr_t [4:0] and word_t [31:0].
  - FSM state enum {CLEAR, RUN}.
- One natural sub-module: mc_regfile_clear_fsm, which owns the sweep counter, state, Ready, and the clear-address/clear-enable outputs.
- The array and read/write muxing stay in mc_regfile.

Test Plan:
- Reset/sweep: rst=1 for 2 cycles, then 0 -> Ready=0 for 32 cycles, Ready=1 on the 33rd edge; A=B=0 throughout.
- Write/read: write R5=0xDEADBEEF; next cycle ReadReg1=5 -> A=0xDEADBEEF one edge later.
- Zero register: write R0=0xFFFFFFFF, then ReadReg1=ReadReg2=0 -> A=B=0.
- Same-cycle collision: R7 holds 0x1111; write R7=0x2222 with ReadReg2=7 in the same cycle -> B=0x1111 without the macro, B=0x2222 with MC_REGFILE_BYPASS_EN; B=0x2222 one cycle later in both builds.
- Write during CLEAR: RegWrite=1, WriteReg=3, data 0xABCD at sweep cycle 10 -> after Ready, R3 reads 0.
- Mid-run reset: fill R1..R31 with their own index, assert rst for 1 cycle -> Ready drops; after the sweep every register reads 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle CPU register file.
package mc_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int         NUM_REGS = 32;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] word_t;

   typedef enum logic {CLEAR, RUN} rf_state_e;

endpackage

// File: rtl/mc_regfile_clear_fsm.sv
// Post-reset clear sweep: walks every entry once, then parks in RUN with Ready high.
module mc_regfile_clear_fsm
   import mc_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   output logic              clear_en,
   output logic [ADDR_W-1:0] clear_addr
);

   rf_state_e       state;
   // Extra top bit marks "all entries written"; the next edge moves to RUN.
   logic [ADDR_W:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               if (cnt[ADDR_W]) begin
                  state <= RUN;
                  ready <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN:     ready <= 1'b1;
            default: state <= CLEAR;
         endcase
      end
   end

   assign clear_en   = (state == CLEAR) && !cnt[ADDR_W];
   assign clear_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/mc_regfile.sv
// 32x32 MIPS register file with registered A/B read ports and one write port.
// Optional write-through on read/write collision: define MC_REGFILE_BYPASS_EN.
module mc_regfile
   import mc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWrite,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              Ready
);

   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic              clear_en;
   logic [ADDR_W-1:0] clear_addr;
   logic              wr_en;

   mc_regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
      .clk        (clk),
      .rst        (rst),
      .ready      (Ready),
      .clear_en   (clear_en),
      .clear_addr (clear_addr)
   );

   assign wr_en = Ready && RegWrite && (WriteReg != ZERO);

   // No reset on the array so it maps onto RAM; the sweep does the clearing.
   always_ff @(posedge clk) begin
      if (clear_en)
         mem[clear_addr] <= '0;
      else if (wr_en)
         mem[WriteReg] <= WriteData;
   end

`ifdef MC_REGFILE_BYPASS_EN
   logic [DATA_W-1:0] rd1, rd2;
   assign rd1 = (wr_en && WriteReg == ReadReg1) ? WriteData : mem[ReadReg1];
   assign rd2 = (wr_en && WriteReg == ReadReg2) ? WriteData : mem[ReadReg2];
`else
   logic [DATA_W-1:0] rd1, rd2;
   assign rd1 = mem[ReadReg1];
   assign rd2 = mem[ReadReg2];
`endif

   always_ff @(posedge clk) begin
      if (rst || !Ready) begin
         A <= '0;
         B <= '0;
      end else begin
         A <= (ReadReg1 == ZERO) ? '0 : rd1;
         B <= (ReadReg2 == ZERO) ? '0 : rd2;
      end
   end

endmodule

// File: tb/tb_mc_regfile.sv
// Directed self-checking bench for mc_regfile; honours MC_REGFILE_BYPASS_EN if defined.
module tb_mc_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  ReadReg1 = '0, ReadReg2 = '0, WriteReg = '0;
   logic [31:0] WriteData = '0;
   logic        RegWrite = 1'b0;
   logic [31:0] A, B;
   logic        Ready;

   int tests = 0;
   int fails = 0;

   mc_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .RegWrite  (RegWrite),
      .A         (A),
      .B         (B),
      .Ready     (Ready)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      RegWrite = 1'b1; WriteReg = a; WriteData = d;
      step();
      RegWrite = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      ReadReg1 = a1; ReadReg2 = a2;
      step();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!Ready && n < 40) begin
         step();
         n++;
      end
      tests++;
      if (Ready !== 1'b1) begin
         fails++;
         $display("FAIL wait_ready: Ready=%b after %0d cycles, need 1", Ready, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      tests++;
      if (A !== 32'h0 || B !== 32'h0 || Ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: A=%h B=%h Ready=%b, need 0 0 0", A, B, Ready);
      end
      rst = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         step();
         tests++;
         if (Ready !== (k == 33) || A !== 32'h0 || B !== 32'h0) begin
            fails++;
            $display("FAIL sweep_edge%0d: Ready=%b A=%h B=%h, need Ready=%b A=B=0",
                     k, Ready, A, B, (k == 33));
         end
      end
   endtask

   task automatic test_write_read();
      wr(5'd5, 32'hDEADBEEF);
      rd(5'd5, 5'd0);
      tests++;
      if (A !== 32'hDEADBEEF || B !== 32'h0) begin
         fails++;
         $display("FAIL write_read_r5: A=%h B=%h, need deadbeef 00000000", A, B);
      end
      wr(5'd31, 32'h0123_4567);
      rd(5'd31, 5'd31);
      tests++;
      if (A !== 32'h0123_4567 || B !== 32'h0123_4567) begin
         fails++;
         $display("FAIL same_addr_r31: A=%h B=%h, need 01234567 both", A, B);
      end
      rd(5'd1, 5'd5);
      tests++;
      if (A !== 32'h0 || B !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL read_r1_r5: A=%h B=%h, need 00000000 deadbeef", A, B);
      end
   endtask

   task automatic test_zero_reg();
      wr(5'd0, 32'hFFFFFFFF);
      rd(5'd0, 5'd0);
      tests++;
      if (A !== 32'h0 || B !== 32'h0) begin
         fails++;
         $display("FAIL zero_reg: A=%h B=%h, need 0 0", A, B);
      end
   endtask

   task automatic test_collision();
      logic [31:0] exp_b;
`ifdef MC_REGFILE_BYPASS_EN
      exp_b = 32'h2222;
`else
      exp_b = 32'h1111;
`endif
      wr(5'd7, 32'h1111);
      ReadReg1 = 5'd0; ReadReg2 = 5'd7;
      RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h2222;
      step();
      RegWrite = 1'b0;
      tests++;
      if (B !== exp_b) begin
         fails++;
         $display("FAIL collision_same_cycle: B=%h, need %h", B, exp_b);
      end
      step();
      tests++;
      if (B !== 32'h2222) begin
         fails++;
         $display("FAIL collision_next_cycle: B=%h, need 00002222", B);
      end
   endtask

   task automatic test_clear_write();
      rst = 1'b1;
      step();
      rst = 1'b0;
      ReadReg1 = 5'd3; ReadReg2 = 5'd3;
      for (int k = 1; k <= 9; k++) step();
      RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hABCD;
      step();
      RegWrite = 1'b0;
      tests++;
      if (Ready !== 1'b0 || A !== 32'h0) begin
         fails++;
         $display("FAIL clear_write_during: Ready=%b A=%h, need 0 0", Ready, A);
      end
      wait_ready();
      rd(5'd3, 5'd3);
      tests++;
      if (A !== 32'h0 || B !== 32'h0) begin
         fails++;
         $display("FAIL clear_write_r3: A=%h B=%h, need 0 0", A, B);
      end
   endtask

   task automatic test_midrun_reset();
      int bad = 0;
      for (int r = 1; r < 32; r++) wr(5'(r), 32'(r));
      rd(5'd17, 5'd31);
      tests++;
      if (A !== 32'd17 || B !== 32'd31) begin
         fails++;
         $display("FAIL fill_check: A=%h B=%h, need 11 1f", A, B);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if (Ready !== 1'b0 || A !== 32'h0 || B !== 32'h0) begin
         fails++;
         $display("FAIL midrun_reset: Ready=%b A=%h B=%h, need 0 0 0", Ready, A, B);
      end
      wait_ready();
      for (int r = 0; r < 32; r++) begin
         rd(5'(r), 5'(31 - r));
         if (A !== 32'h0 || B !== 32'h0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL midrun_cleared: %0d reads nonzero, need 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero_reg();
      test_collision();
      test_clear_write();
      test_midrun_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
